// File: rtl/screen_fade_ctrl_pkg.sv
// ============================================================================
// screen_pkg : screen ids, fade FSM states and brightness limits
// Rev 1.0
// ============================================================================
`default_nettype none

package screen_pkg;

    typedef enum logic [2:0] {
        SCR_TITLE  = 3'd0,
        SCR_MENU   = 3'd1,
        SCR_LEVEL1 = 3'd2,
        SCR_LEVEL2 = 3'd3,
        SCR_LEVEL3 = 3'd4,
        SCR_FINISH = 3'd5
    } screen_t;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_FADE_OUT = 3'd1,
        ST_HOLD     = 3'd2,
        ST_SWAP     = 3'd3,
        ST_FADE_IN  = 3'd4
    } fade_state_t;

    localparam logic [4:0] LEVEL_MAX = 5'd16;

endpackage

`default_nettype wire

// File: rtl/screen_fade_ctrl_if.sv
// ============================================================================
// screen_fade_ctrl_if : request handshake, status and pixel path bundle
// Rev 1.0
// ============================================================================
`default_nettype none

interface screen_fade_ctrl_if;
    import screen_pkg::*;

    logic        frame_start;
    logic        req_valid;
    screen_t     req_screen;
    logic        req_ready;
    logic        busy;
    logic        done;
    logic        swap;
    screen_t     screen_sel;
    logic        pix_de_in;
    logic [11:0] rgb_in;
    logic        pix_de_out;
    logic [11:0] rgb_out;

    modport master (
        output frame_start, req_valid, req_screen, pix_de_in, rgb_in,
        input  req_ready, busy, done, swap, screen_sel, pix_de_out, rgb_out
    );

    modport slave (
        input  frame_start, req_valid, req_screen, pix_de_in, rgb_in,
        output req_ready, busy, done, swap, screen_sel, pix_de_out, rgb_out
    );

endinterface

`default_nettype wire

// File: rtl/screen_fade_ctrl_rgb_scale.sv
// ============================================================================
// rgb_scale : combinational per-channel (in*level)>>4 on 4:4:4 RGB
// Rev 1.0
// ============================================================================
`default_nettype none

module rgb_scale (
    input  wire logic [11:0] i_rgb,
    input  wire logic [4:0]  i_level,
    output logic      [11:0] o_rgb
);

    for (genvar g = 0; g < 3; g++) begin : g_ch
        logic [7:0] w_prod;
        // 15*16 = 240 fits in 8 bits, so no overflow before the shift
        assign w_prod               = {4'd0, i_rgb[g*4 +: 4]} * {3'd0, i_level};
        assign o_rgb[g*4 +: 4]      = w_prod[7:4];
    end

endmodule

`default_nettype wire

// File: rtl/screen_fade_ctrl.sv
// ============================================================================
// screen_fade_ctrl : fade-out / screen swap / fade-in sequencer with RGB scaling
// Optional macro FADE_HOLD_BLACK_EN : hold at black for HOLD_FRAMES frames
// Rev 1.0
// ============================================================================
`default_nettype none

module screen_fade_ctrl
    import screen_pkg::*;
#(
    parameter int      FRAMES_PER_STEP = 2,
    parameter screen_t INIT_SCREEN     = SCR_TITLE,
    parameter int      HOLD_FRAMES     = 8
) (
    input wire logic          Clk,
    input wire logic          Reset_n,
    screen_fade_ctrl_if.slave bus
);

    localparam logic [7:0] c_STEP_LAST = 8'(FRAMES_PER_STEP - 1);

    fade_state_t r_state,      w_state_nxt;
    logic [4:0]  r_level,      w_level_nxt;
    logic [7:0]  r_step_cnt,   w_step_nxt;
    screen_t     r_target,     w_target_nxt;
    screen_t     r_screen_sel, w_sel_nxt;
    logic        r_done,       w_done_nxt;
    logic        r_swap,       w_swap_nxt;
    logic [11:0] r_rgb;
    logic        r_de;
    logic [11:0] w_scaled;
    logic        w_step_last;

`ifdef FADE_HOLD_BLACK_EN
    localparam logic [7:0] c_HOLD_LAST = 8'(HOLD_FRAMES - 1);
    logic [7:0]  r_hold_cnt,   w_hold_nxt;
`else
    wire logic [7:0] w_unused_hold = 8'(HOLD_FRAMES);
`endif

    assign w_step_last = (r_step_cnt == c_STEP_LAST);

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state      <= ST_IDLE;
            r_level      <= LEVEL_MAX;
            r_step_cnt   <= 8'd0;
            r_target     <= INIT_SCREEN;
            r_screen_sel <= INIT_SCREEN;
            r_done       <= 1'b0;
            r_swap       <= 1'b0;
`ifdef FADE_HOLD_BLACK_EN
            r_hold_cnt   <= 8'd0;
`endif
        end else begin
            r_state      <= w_state_nxt;
            r_level      <= w_level_nxt;
            r_step_cnt   <= w_step_nxt;
            r_target     <= w_target_nxt;
            r_screen_sel <= w_sel_nxt;
            r_done       <= w_done_nxt;
            r_swap       <= w_swap_nxt;
`ifdef FADE_HOLD_BLACK_EN
            r_hold_cnt   <= w_hold_nxt;
`endif
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_level_nxt  = r_level;
        w_step_nxt   = r_step_cnt;
        w_target_nxt = r_target;
        w_sel_nxt    = r_screen_sel;
        w_done_nxt   = 1'b0;
        w_swap_nxt   = 1'b0;
`ifdef FADE_HOLD_BLACK_EN
        w_hold_nxt   = r_hold_cnt;
`endif
        case (r_state)
            ST_IDLE: begin
                // frame_start is deliberately not looked at here
                if (bus.req_valid) begin
                    w_target_nxt = bus.req_screen;
                    if (bus.req_screen == r_screen_sel) begin
                        w_done_nxt = 1'b1;
                    end else begin
                        w_state_nxt = ST_FADE_OUT;
                        w_step_nxt  = 8'd0;
                    end
                end
            end
            ST_FADE_OUT: begin
                if (bus.frame_start) begin
                    if (w_step_last) begin
                        w_step_nxt  = 8'd0;
                        w_level_nxt = r_level - 5'd1;
                        if (r_level == 5'd1) begin
                            w_state_nxt = ST_HOLD;
`ifdef FADE_HOLD_BLACK_EN
                            w_hold_nxt  = 8'd0;
`endif
                        end
                    end else begin
                        w_step_nxt = r_step_cnt + 8'd1;
                    end
                end
            end
            ST_HOLD: begin
`ifdef FADE_HOLD_BLACK_EN
                if (bus.frame_start) begin
                    if (r_hold_cnt == c_HOLD_LAST) begin
                        w_state_nxt = ST_SWAP;
                    end else begin
                        w_hold_nxt = r_hold_cnt + 8'd1;
                    end
                end
`else
                w_state_nxt = ST_SWAP;
`endif
            end
            ST_SWAP: begin
                w_sel_nxt   = r_target;
                w_swap_nxt  = 1'b1;
                w_step_nxt  = 8'd0;
                w_state_nxt = ST_FADE_IN;
            end
            ST_FADE_IN: begin
                if (bus.frame_start) begin
                    if (w_step_last) begin
                        w_step_nxt  = 8'd0;
                        w_level_nxt = r_level + 5'd1;
                        if (r_level == LEVEL_MAX - 5'd1) begin
                            w_state_nxt = ST_IDLE;
                            w_done_nxt  = 1'b1;
                        end
                    end else begin
                        w_step_nxt = r_step_cnt + 8'd1;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    rgb_scale u_rgb_scale (
        .i_rgb   (bus.rgb_in),
        .i_level (r_level),
        .o_rgb   (w_scaled)
    );

    // Pixel path is independent of the FSM: one register stage in every state
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_rgb <= 12'h000;
            r_de  <= 1'b0;
        end else begin
            r_rgb <= bus.pix_de_in ? w_scaled : 12'h000;
            r_de  <= bus.pix_de_in;
        end
    end

    assign bus.req_ready  = (r_state == ST_IDLE);
    assign bus.busy       = (r_state != ST_IDLE);
    assign bus.done       = r_done;
    assign bus.swap       = r_swap;
    assign bus.screen_sel = r_screen_sel;
    assign bus.rgb_out    = r_rgb;
    assign bus.pix_de_out = r_de;

endmodule

`default_nettype wire

// File: tb/tb_screen_fade_ctrl.sv
// ============================================================================
// tb_screen_fade_ctrl : vector table plus fade sequences for screen_fade_ctrl
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_screen_fade_ctrl;
    import screen_pkg::*;

`ifdef FADE_HOLD_BLACK_EN
    localparam int HOLD_N = 3;
`else
    localparam int HOLD_N = 0;
`endif
    localparam int XFER_LAST = 64 + HOLD_N;

    typedef struct {
        logic [11:0] rgb;
        logic        de;
        logic [4:0]  lvl;
        logic [11:0] exp;
    } vec_t;

    typedef struct {
        logic [11:0] rgb;
        logic        de;
    } pix_t;

    logic Clk;
    logic Reset_n;

    int errors    = 0;
    int checks    = 0;
    int swap_cnt  = 0;
    int done_cnt  = 0;
    int busy_gap  = 0;
    bit in_xfer   = 0;
    logic [2:0] swap_sel = 3'd7;

    vec_t tbl [8];
    pix_t exp_q [$];

    screen_fade_ctrl_if bus ();

    screen_fade_ctrl #(
        .FRAMES_PER_STEP (2),
        .INIT_SCREEN     (SCR_TITLE),
        .HOLD_FRAMES     (3)
    ) dut (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .bus     (bus)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, required finish");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
        if (bus.swap) begin
            swap_cnt++;
            swap_sel = bus.screen_sel;
        end
        if (bus.done) begin
            done_cnt++;
            in_xfer = 1'b0;
        end else if (in_xfer && !bus.busy) begin
            busy_gap++;
        end
    endtask

    task automatic frame();
        bus.frame_start = 1'b1;
        tick();
        bus.frame_start = 1'b0;
        tick();
        tick();
    endtask

    // Push expectation for current pixel stimulus, let one edge pass, compare
    task automatic sb_check(input string name, input logic [11:0] rgb_exp, input logic de_exp);
        pix_t e;
        pix_t p;
        e.rgb = rgb_exp;
        e.de  = de_exp;
        exp_q.push_back(e);
        tick();
        p = exp_q.pop_front();
        chk({name, "_rgb"}, bus.rgb_out, p.rgb);
        chk({name, "_de"},  bus.pix_de_out, p.de);
    endtask

    task automatic apply_vec(input int i);
        bus.rgb_in    = tbl[i].rgb;
        bus.pix_de_in = tbl[i].de;
        sb_check($sformatf("vec%0d", i), tbl[i].exp, tbl[i].de);
    endtask

    function automatic int exp_level(input int k);
        int j;
        if (k <= 32) return 16 - k / 2;
        if (k <= 32 + HOLD_N) return 0;
        j = (k - 32 - HOLD_N) / 2;
        return (j > 16) ? 16 : j;
    endfunction

    // Brightness seen through a full-white input
    function automatic logic [11:0] lvl_rgb(input int lvl);
        logic [3:0] c;
        c = 4'((15 * lvl) >> 4);
        return {c, c, c};
    endfunction

    task automatic run_xfer(input int k_from, input int k_to, input logic [2:0] tgt);
        for (int k = k_from; k <= k_to; k++) begin
            frame();
            if (k == 2 || k % 8 == 0 || k == 31 + HOLD_N || k == XFER_LAST)
                sb_check($sformatf("level_k%0d", k), lvl_rgb(exp_level(k)), 1'b1);
            if (HOLD_N > 0 && k == 31 + HOLD_N)
                chk("no_swap_during_hold", swap_cnt, 0);
            if (k == 32 + HOLD_N) begin
                chk("swap_once_at_black", swap_cnt, 1);
                chk("sel_at_swap", swap_sel, tgt);
            end
        end
    endtask

    task automatic request(input screen_t scr);
        bus.req_valid  = 1'b1;
        bus.req_screen = scr;
        tick();
        bus.req_valid  = 1'b0;
    endtask

    initial begin
        tbl[0] = '{12'hFFF, 1'b1, 5'd16, 12'hFFF};
        tbl[1] = '{12'h3A9, 1'b1, 5'd16, 12'h3A9};
        tbl[2] = '{12'h123, 1'b0, 5'd16, 12'h000};
        tbl[3] = '{12'h000, 1'b1, 5'd16, 12'h000};
        tbl[4] = '{12'hFFF, 1'b1, 5'd8,  12'h777};
        tbl[5] = '{12'h3A9, 1'b1, 5'd8,  12'h154};
        tbl[6] = '{12'hABC, 1'b0, 5'd8,  12'h000};
        tbl[7] = '{12'h8C1, 1'b1, 5'd8,  12'h460};

        Reset_n         = 1'b0;
        bus.frame_start = 1'b0;
        bus.req_valid   = 1'b0;
        bus.req_screen  = SCR_TITLE;
        bus.pix_de_in   = 1'b1;
        bus.rgb_in      = 12'hFFF;
        #3;
        chk("rst_req_ready", bus.req_ready, 1);
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_swap", bus.swap, 0);
        chk("rst_screen_sel", bus.screen_sel, SCR_TITLE);
        chk("rst_rgb_out", bus.rgb_out, 12'h000);
        chk("rst_de_out", bus.pix_de_out, 0);
        @(negedge Clk);
        Reset_n = 1'b1;
        tick();

        for (int i = 0; i < 8; i++)
            if (tbl[i].lvl == 5'd16) apply_vec(i);

        // Same-screen request: immediate done, no fade
        bus.rgb_in    = 12'hFFF;
        bus.pix_de_in = 1'b1;
        swap_cnt = 0;
        done_cnt = 0;
        request(SCR_TITLE);
        chk("same_done_pulse", bus.done, 1);
        chk("same_busy", bus.busy, 0);
        tick();
        chk("same_done_clear", bus.done, 0);
        chk("same_busy_after", bus.busy, 0);
        chk("same_no_swap", swap_cnt, 0);
        sb_check("same_level16", 12'hFFF, 1'b1);

        // Transition 1: TITLE -> LEVEL1, scaling table at level 8
        swap_cnt = 0;
        done_cnt = 0;
        busy_gap = 0;
        request(SCR_LEVEL1);
        in_xfer = 1'b1;
        chk("x1_busy", bus.busy, 1);
        chk("x1_req_ready", bus.req_ready, 0);
        run_xfer(1, 16, SCR_LEVEL1);
        for (int i = 0; i < 8; i++)
            if (tbl[i].lvl == 5'd8) apply_vec(i);
        bus.rgb_in    = 12'hFFF;
        bus.pix_de_in = 1'b1;
        run_xfer(17, XFER_LAST, SCR_LEVEL1);
        chk("x1_done_once", done_cnt, 1);
        chk("x1_swap_once", swap_cnt, 1);
        chk("x1_busy_gaps", busy_gap, 0);
        chk("x1_final_sel", bus.screen_sel, SCR_LEVEL1);
        chk("x1_idle", bus.req_ready, 1);

        // Transition 2: LEVEL1 -> LEVEL3 with a MENU request held while busy
        swap_cnt = 0;
        done_cnt = 0;
        busy_gap = 0;
        bus.req_valid  = 1'b1;
        bus.req_screen = SCR_LEVEL3;
        tick();
        in_xfer = 1'b1;
        bus.req_screen = SCR_MENU;
        run_xfer(1, 10, SCR_LEVEL3);
        chk("x2_not_ready", bus.req_ready, 0);
        bus.req_valid = 1'b0;
        run_xfer(11, XFER_LAST, SCR_LEVEL3);
        chk("x2_done_once", done_cnt, 1);
        chk("x2_swap_once", swap_cnt, 1);
        chk("x2_busy_gaps", busy_gap, 0);
        chk("x2_final_sel", bus.screen_sel, SCR_LEVEL3);

        // Transition 3: LEVEL3 -> FINISH, reset at level 5 in fade-in
        swap_cnt = 0;
        done_cnt = 0;
        request(SCR_FINISH);
        in_xfer = 1'b1;
        run_xfer(1, 42 + HOLD_N, SCR_FINISH);
        sb_check("x3_level5", lvl_rgb(5), 1'b1);
        chk("x3_busy_pre_reset", bus.busy, 1);
        Reset_n = 1'b0;
        in_xfer = 1'b0;
        #2;
        chk("mid_rst_req_ready", bus.req_ready, 1);
        chk("mid_rst_busy", bus.busy, 0);
        chk("mid_rst_sel", bus.screen_sel, SCR_TITLE);
        chk("mid_rst_rgb", bus.rgb_out, 12'h000);
        chk("mid_rst_de", bus.pix_de_out, 0);
        chk("mid_rst_swap", bus.swap, 0);
        #2;
        Reset_n = 1'b1;
        tick();
        sb_check("post_rst_level16", 12'hFFF, 1'b1);
        chk("post_rst_sel", bus.screen_sel, SCR_TITLE);
        chk("post_rst_no_done", done_cnt, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
